// File: rtl/avr_prefetch.sv
// Instruction prefetch queue for an AVR-style core: fetches program words, queues them, flushes on redirect.
// Define AVR_PREFETCH_LONG_EN to decode 32-bit opcodes (JMP/CALL/LDS/STS) and pair their two words.
module avr_prefetch #(
  parameter int              PC_W      = 16,
  parameter int              DEPTH     = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  output logic                       o_prog_req,
  output logic [PC_W-1:0]            o_prog_addr,
  input  logic                       i_prog_ack,
  input  logic                       i_prog_valid,
  input  logic [15:0]                i_prog_data,
  input  logic                       i_redirect,
  input  logic [PC_W-1:0]            i_redirect_pc,
  input  logic                       i_instr_ready,
  output logic                       o_instr_valid,
  output logic [15:0]                o_instr,
  output logic [15:0]                o_instr_hi,
  output logic                       o_instr_len,
  output logic [PC_W-1:0]            o_instr_pc,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {S_FETCH, S_FULL, S_FLUSH} state_t;

  state_t            r_state, w_state_n;
  logic              r_go;
  logic [PC_W-1:0]   r_pc, r_rpc;
  logic [LW-1:0]     r_out, r_drop, r_level;
  logic [AW-1:0]     r_rd, r_wr;
  logic [15:0]       r_data [DEPTH];
  logic [PC_W-1:0]   r_qpc  [DEPTH];

  logic [LW:0]       w_sum;
  logic              w_room, w_acc, w_vin, w_push, w_pop;
  logic              w_nonempty, w_len;
  logic [LW-1:0]     w_out_n, w_drop_n, w_popn;
  logic [AW-1:0]     w_rd_step;
  logic [15:0]       w_head;

  assign w_sum      = {1'b0, r_level} + {1'b0, r_out};
  assign w_room     = w_sum < (LW+1)'(DEPTH);
  assign o_prog_req = (r_state == S_FETCH) & r_go & w_room;
  assign o_prog_addr = r_pc;
  assign o_level    = r_level;

  assign w_acc   = o_prog_req & i_prog_ack;
  // Returns with nothing in flight are stale and never counted.
  assign w_vin   = i_prog_valid & (r_out != '0);
  assign w_out_n = r_out + LW'(w_acc) - LW'(w_vin);
  assign w_push  = w_vin & (r_state != S_FLUSH) & ~i_redirect;

  assign w_nonempty = r_level != '0;
  assign w_head     = r_data[r_rd];

`ifdef AVR_PREFETCH_LONG_EN
  logic [AW-1:0] w_rd1;
  logic          w_long;
  assign w_rd1  = r_rd + AW'(1);
  assign w_long = (w_head[15:9] == 7'b1001010 && w_head[3:2] == 2'b11) ||
                  (w_head[15:10] == 6'b100100 && w_head[3:0] == 4'b0000);
  assign w_len         = w_nonempty & w_long;
  assign o_instr_valid = w_nonempty & (~w_long | (r_level >= LW'(2)));
  assign o_instr_hi    = (o_instr_valid & w_long) ? r_data[w_rd1] : 16'h0000;
`else
  assign w_len         = 1'b0;
  assign o_instr_valid = w_nonempty;
  assign o_instr_hi    = 16'h0000;
`endif

  assign o_instr_len = w_len;
  assign o_instr     = w_nonempty ? w_head : 16'h0000;
  assign o_instr_pc  = w_nonempty ? r_qpc[r_rd] : r_pc;

  assign w_pop     = o_instr_valid & i_instr_ready & ~i_redirect;
  assign w_popn    = w_pop ? (w_len ? LW'(2) : LW'(1)) : '0;
  assign w_rd_step = w_len ? AW'(2) : AW'(1);

  always_comb begin
    w_drop_n = r_drop;
    if (r_state == S_FLUSH && w_vin && r_drop != '0)
      w_drop_n = r_drop - LW'(1);
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      S_FETCH: if (!w_room) w_state_n = S_FULL;
      S_FULL:  if (w_room)  w_state_n = S_FETCH;
      S_FLUSH: if (w_drop_n == '0) w_state_n = S_FETCH;
      default: w_state_n = S_FETCH;
    endcase
    // Every request still in flight at a redirect belongs to the old stream.
    if (i_redirect)
      w_state_n = (w_out_n != '0) ? S_FLUSH : S_FETCH;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_FETCH;
      r_go    <= 1'b0;
      r_pc    <= RESET_VEC;
      r_rpc   <= RESET_VEC;
      r_out   <= '0;
      r_drop  <= '0;
      r_level <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
    end else begin
      r_go    <= 1'b1;
      r_state <= w_state_n;
      r_out   <= w_out_n;
      if (i_redirect) begin
        r_pc    <= i_redirect_pc;
        r_rpc   <= i_redirect_pc;
        r_drop  <= w_out_n;
        r_level <= '0;
        r_rd    <= '0;
        r_wr    <= '0;
      end else begin
        r_drop <= w_drop_n;
        if (w_acc) r_pc <= r_pc + PC_W'(1);
        if (w_push) begin
          r_wr  <= r_wr + AW'(1);
          r_rpc <= r_rpc + PC_W'(1);
        end
        if (w_pop) r_rd <= r_rd + w_rd_step;
        r_level <= r_level + LW'(w_push) - w_popn;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_data[r_wr] <= {i_prog_data[7:0], i_prog_data[15:8]};
      r_qpc[r_wr]  <= r_rpc;
    end
  end

endmodule
